// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment display scanner: segment constants,
// FSM state encoding and the hex-digit to active-low segment decoder.
package seg_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'hBF;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SHIFT = 2'd1,
    WRITE = 2'd2
  } state_e;

  // Active-low {dp,g,f,e,d,c,b,a}; dp is always off.
  function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
    logic [7:0] s;
    case (nib)
      4'h0:    s = 8'hC0;
      4'h1:    s = 8'hF9;
      4'h2:    s = 8'hA4;
      4'h3:    s = 8'hB0;
      4'h4:    s = 8'h99;
      4'h5:    s = 8'h92;
      4'h6:    s = 8'h82;
      4'h7:    s = 8'hF8;
      4'h8:    s = 8'h80;
      4'h9:    s = 8'h90;
      4'hA:    s = 8'h88;
      4'hB:    s = 8'h83;
      4'hC:    s = 8'hC6;
      4'hD:    s = 8'hA1;
      4'hE:    s = 8'h86;
      4'hF:    s = 8'h8E;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg_bin2bcd.sv
// Sequential shift-add-3 binary to BCD converter, one bit per cycle.
// Keeps one guard digit above the displayed digits plus a sticky flag for
// bits pushed out of the top, so any value that does not fit is flagged.
module seg_bin2bcd
  import seg_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int DIGITS_PER_CH = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         load,
  input  logic                         shift,
  input  logic [WIDTH-1:0]             bin_in,
  output logic [4*DIGITS_PER_CH-1:0]   bcd,
  output logic                         ovf
);

  localparam int BCD_W = 4*DIGITS_PER_CH + 4;

  logic [BCD_W-1:0] bcd_q, bcd_d, adj_s;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic             lost_q, lost_d;

  // Add 3 to every digit (guard digit included) that is 5 or more.
  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i < DIGITS_PER_CH + 1; i++) begin
      r[4*i +: 4] = (b[4*i +: 4] >= 4'd5) ? (b[4*i +: 4] + 4'd3) : b[4*i +: 4];
    end
    return r;
  endfunction

  // Next value of the {bcd,bin} shift pair and the sticky lost-bit flag.
  always_comb begin
    adj_s  = add3(bcd_q);
    bcd_d  = bcd_q;
    bin_d  = bin_q;
    lost_d = lost_q;
    if (load) begin
      bcd_d  = '0;
      bin_d  = bin_in;
      lost_d = 1'b0;
    end else if (shift) begin
      bcd_d  = {adj_s[BCD_W-2:0], bin_q[WIDTH-1]};
      bin_d  = {bin_q[WIDTH-2:0], 1'b0};
      lost_d = lost_q | adj_s[BCD_W-1];
    end else begin
      bcd_d  = bcd_q;
      bin_d  = bin_q;
      lost_d = lost_q;
    end
  end

  // Converter state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_q  <= '0;
      bin_q  <= '0;
      lost_q <= 1'b0;
    end else begin
      bcd_q  <= bcd_d;
      bin_q  <= bin_d;
      lost_q <= lost_d;
    end
  end

  assign bcd = bcd_q[4*DIGITS_PER_CH-1:0];
  assign ovf = lost_q | (bcd_q[BCD_W-1 -: 4] != 4'd0);

endmodule

// File: rtl/seg_display_scanner.sv
// Round-robin display back-end: converts each channel value to hex or
// decimal digits, applies overflow dashes and leading-zero blanking, and
// writes that channel's active-low segment field. Free-running, no idle.
module seg_display_scanner
  import seg_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int NUM_CH        = 2,
  parameter int DIGITS_PER_CH = 3
) (
  input  logic                              CLOCK,
  input  logic                              nRESET,
  input  logic [NUM_CH*WIDTH-1:0]           VALUES,
  input  logic                              DEC_MODE,
  input  logic                              LZ_BLANK,
  output logic [NUM_CH*DIGITS_PER_CH*8-1:0] SEG,
  output logic                              FRAME_DONE
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int HEX_W = 4*DIGITS_PER_CH;
  localparam int EXT_W = (WIDTH > HEX_W) ? WIDTH : HEX_W;
  localparam int SEG_W = NUM_CH*DIGITS_PER_CH*8;
  localparam int FLD_W = DIGITS_PER_CH*8;

  state_e             state_q, state_d;
  logic [CH_W-1:0]    ch_q, ch_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   value_q, value_d;
  logic               dec_q, dec_d;
  logic               lz_q, lz_d;
  logic [SEG_W-1:0]   seg_q, seg_d;
  logic               fd_q, fd_d;

  logic [WIDTH-1:0]   chan_val_s;
  logic               bcd_load_s;
  logic               bcd_shift_s;
  logic [HEX_W-1:0]   bcd_s;
  logic               bcd_ovf_s;
  logic [EXT_W-1:0]   ext_s;
  logic               hex_ovf_s;
  logic               ovf_s;
  logic               lead_s;
  logic [3:0]         nib_s;
  logic [FLD_W-1:0]   digit_seg_s;

  seg_bin2bcd #(
    .WIDTH         (WIDTH),
    .DIGITS_PER_CH (DIGITS_PER_CH)
  ) u_bin2bcd (
    .clk    (CLOCK),
    .rst_n  (nRESET),
    .load   (bcd_load_s),
    .shift  (bcd_shift_s),
    .bin_in (chan_val_s),
    .bcd    (bcd_s),
    .ovf    (bcd_ovf_s)
  );

  // Select the current channel's slice of VALUES.
  always_comb begin
    chan_val_s = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      chan_val_s = (ch_q == CH_W'(c)) ? VALUES[c*WIDTH +: WIDTH] : chan_val_s;
    end
  end

  // Build the digit patterns for the captured value: overflow, blanking, decode.
  always_comb begin
    ext_s     = EXT_W'(value_q);
    hex_ovf_s = 1'b0;
    for (int i = 0; i < EXT_W; i++) begin
      hex_ovf_s = (i >= HEX_W) ? (hex_ovf_s | ext_s[i]) : hex_ovf_s;
    end
    ovf_s       = dec_q ? bcd_ovf_s : hex_ovf_s;
    lead_s      = 1'b1;
    nib_s       = 4'd0;
    digit_seg_s = '0;
    for (int k = DIGITS_PER_CH - 1; k >= 0; k--) begin
      nib_s = dec_q ? bcd_s[4*k +: 4] : ext_s[4*k +: 4];
      if (ovf_s) begin
        digit_seg_s[8*k +: 8] = SEG_DASH;
      end else if (lz_q && lead_s && (nib_s == 4'd0) && (k != 0)) begin
        digit_seg_s[8*k +: 8] = SEG_BLANK;
      end else begin
        digit_seg_s[8*k +: 8] = hex_to_seg(nib_s);
        lead_s                = 1'b0;
      end
    end
  end

  // FSM next state, channel sequencing and segment field update.
  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    cnt_d       = cnt_q;
    value_d     = value_q;
    dec_d       = dec_q;
    lz_d        = lz_q;
    seg_d       = seg_q;
    fd_d        = 1'b0;
    bcd_load_s  = 1'b0;
    bcd_shift_s = 1'b0;
    case (state_q)
      LOAD: begin
        value_d    = chan_val_s;
        dec_d      = DEC_MODE;
        lz_d       = LZ_BLANK;
        cnt_d      = CNT_W'(WIDTH);
        bcd_load_s = 1'b1;
        state_d    = DEC_MODE ? SHIFT : WRITE;
      end
      SHIFT: begin
        bcd_shift_s = 1'b1;
        cnt_d       = cnt_q - CNT_W'(1);
        state_d     = (cnt_q == CNT_W'(1)) ? WRITE : SHIFT;
      end
      WRITE: begin
        for (int c = 0; c < NUM_CH; c++) begin
          seg_d[c*FLD_W +: FLD_W] = (ch_q == CH_W'(c)) ? digit_seg_s : seg_q[c*FLD_W +: FLD_W];
        end
        if (ch_q == CH_W'(NUM_CH - 1)) begin
          ch_d = '0;
          fd_d = 1'b1;
        end else begin
          ch_d = ch_q + CH_W'(1);
          fd_d = 1'b0;
        end
        state_d = LOAD;
      end
      default: begin
        state_d = LOAD;
      end
    endcase
  end

  // State, capture and output registers; SEG blanks as soon as reset asserts.
  always_ff @(posedge CLOCK or negedge nRESET) begin
    if (!nRESET) begin
      state_q <= LOAD;
      ch_q    <= '0;
      cnt_q   <= '0;
      value_q <= '0;
      dec_q   <= 1'b0;
      lz_q    <= 1'b0;
      seg_q   <= '1;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      cnt_q   <= cnt_d;
      value_q <= value_d;
      dec_q   <= dec_d;
      lz_q    <= lz_d;
      seg_q   <= seg_d;
      fd_q    <= fd_d;
    end
  end

  assign SEG        = seg_q;
  assign FRAME_DONE = fd_q;

endmodule

// File: tb/tb_seg_display_scanner.sv
// Directed self-checking bench for seg_display_scanner: default geometry,
// plus a 2-digit decimal and a 1-digit hex instance for overflow boundaries.
module tb_seg_display_scanner;

  logic        CLOCK = 1'b0;
  logic        nRESET;

  logic [15:0] values;
  logic        dec_mode, lz_blank;
  logic [47:0] seg;
  logic        frame_done;

  logic [7:0]  values2;
  logic        dec2, lz2;
  logic [15:0] seg2;
  logic        fd2;

  logic [7:0]  values1;
  logic        dec1, lz1;
  logic [7:0]  seg1;
  logic        fd1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 CLOCK = ~CLOCK;

  seg_display_scanner #(.WIDTH(8), .NUM_CH(2), .DIGITS_PER_CH(3)) dut (
    .CLOCK(CLOCK), .nRESET(nRESET), .VALUES(values), .DEC_MODE(dec_mode),
    .LZ_BLANK(lz_blank), .SEG(seg), .FRAME_DONE(frame_done)
  );

  seg_display_scanner #(.WIDTH(8), .NUM_CH(1), .DIGITS_PER_CH(2)) dut_d2 (
    .CLOCK(CLOCK), .nRESET(nRESET), .VALUES(values2), .DEC_MODE(dec2),
    .LZ_BLANK(lz2), .SEG(seg2), .FRAME_DONE(fd2)
  );

  seg_display_scanner #(.WIDTH(8), .NUM_CH(1), .DIGITS_PER_CH(1)) dut_d1 (
    .CLOCK(CLOCK), .nRESET(nRESET), .VALUES(values1), .DEC_MODE(dec1),
    .LZ_BLANK(lz1), .SEG(seg1), .FRAME_DONE(fd1)
  );

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Count cycles until FRAME_DONE is seen high (sampled on the falling edge).
  task automatic wait_fd(output int n);
    n = 0;
    do begin
      @(posedge CLOCK);
      n++;
      @(negedge CLOCK);
    end while (!frame_done && n < 200);
    if (!frame_done) check_value("fd_timeout", 64'(frame_done), 64'd1);
  endtask

  // Two frame boundaries guarantee one whole frame with the current inputs.
  task automatic settle();
    int n;
    wait_fd(n);
    wait_fd(n);
  endtask

  task automatic small_wait();
    repeat (30) @(posedge CLOCK);
    @(negedge CLOCK);
  endtask

  initial begin
    int  n;
    logic got;

    nRESET   = 1'b0;
    values   = {8'd7, 8'd205};
    dec_mode = 1'b1;
    lz_blank = 1'b0;
    values2  = 8'd150;
    dec2     = 1'b1;
    lz2      = 1'b0;
    values1  = 8'h1F;
    dec1     = 1'b0;
    lz1      = 1'b0;

    repeat (3) @(negedge CLOCK);
    check_value("reset_seg", 64'(seg), 64'hFFFF_FFFF_FFFF);
    check_value("reset_fd", 64'(frame_done), 64'd0);
    nRESET = 1'b1;

    // First frame after reset, decimal, no blanking.
    wait_fd(n);
    check_value("first_frame_latency", 64'(n), 64'd20);
    check_value("dec_205_7", 64'(seg), 64'hC0C0F8_A4C092);

    // Leading-zero blanking in decimal.
    lz_blank = 1'b1;
    values   = {8'd0, 8'd7};
    settle();
    check_value("dec_lz_7_0", 64'(seg), 64'hFFFFC0_FFFFF8);
    values[7:0] = 8'd105;
    settle();
    check_value("dec_lz_inner_zero", 64'(seg), 64'hFFFFC0_F9C092);

    // Decimal range edges.
    lz_blank = 1'b0;
    values   = {8'd100, 8'd255};
    settle();
    check_value("dec_255_100", 64'(seg), 64'hF9C0C0_A49292);

    // Hex mode: frame rate and digits.
    dec_mode = 1'b0;
    values   = {8'h05, 8'hAB};
    settle();
    wait_fd(n);
    check_value("hex_frame_period", 64'(n), 64'd4);
    check_value("hex_ab_05", 64'(seg), 64'hC0C092_C08883);
    lz_blank = 1'b1;
    settle();
    check_value("hex_lz_ab_05", 64'(seg), 64'hFFFF92_FF8883);

    // Narrow instances: overflow dashes and their edges.
    check_value("d2_dec_150", 64'(seg2), 64'hBFBF);
    check_value("d1_hex_1f", 64'(seg1), 64'hBF);
    values2 = 8'd99;
    values1 = 8'h0F;
    small_wait();
    check_value("d2_dec_99", 64'(seg2), 64'h9090);
    check_value("d1_hex_0f", 64'(seg1), 64'h8E);
    values2 = 8'd100;
    small_wait();
    check_value("d2_dec_100", 64'(seg2), 64'hBFBF);
    values2 = 8'd10;
    small_wait();
    check_value("d2_dec_10", 64'(seg2), 64'hF9C0);
    lz2     = 1'b1;
    values2 = 8'd5;
    small_wait();
    check_value("d2_dec_lz_5", 64'(seg2), 64'hFF92);

    // Asynchronous reset during the SHIFT phase of channel 1.
    dec_mode = 1'b1;
    lz_blank = 1'b0;
    values   = {8'd7, 8'd205};
    settle();
    wait_fd(n);
    repeat (12) @(posedge CLOCK);
    #2 nRESET = 1'b0;
    #1;
    check_value("async_reset_seg", 64'(seg), 64'hFFFF_FFFF_FFFF);
    check_value("async_reset_fd", 64'(frame_done), 64'd0);
    @(negedge CLOCK);
    nRESET = 1'b1;
    n   = 0;
    got = 1'b0;
    while (!got && n < 200) begin
      @(posedge CLOCK);
      n++;
      @(negedge CLOCK);
      if (n == 10) check_value("restart_ch0_first", 64'(seg), 64'hFFFFFF_A4C092);
      got = frame_done;
    end
    check_value("restart_frame_latency", 64'(n), 64'd20);
    check_value("restart_full_frame", 64'(seg), 64'hC0C0F8_A4C092);

    // A VALUES change during SHIFT of ch0 shows up only a frame later.
    repeat (3) @(posedge CLOCK);
    #1 values[7:0] = 8'd105;
    wait_fd(n);
    check_value("mid_shift_change_ignored", 64'(seg), 64'hC0C0F8_A4C092);
    wait_fd(n);
    check_value("mid_shift_change_next", 64'(seg), 64'hC0C0F8_F9C092);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
